// File: rtl/gba_cart_bus_arbiter.sv
// gba_cart_bus_arbiter
// Round-robin arbiter and cycle-accurate sequencer for the GBA cartridge bus.
// One requestor owns the bus at a time. An access is ACCESS for W cycles, then
// one RECOVER cycle that returns the response. Back-to-back same-port,
// same-direction, incrementing accesses use the shorter sequential wait count.
// Every output is registered except req_ready, which is combinational.

module gba_cart_bus_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int WAIT_FIRST = 4,
  parameter int WAIT_SEQ   = 2
) (
  input  logic                        clk_74a,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           cart_addr,
  output logic [DATA_W-1:0]           cart_wdata,
  output logic                        cart_oe,
  input  logic [DATA_W-1:0]           cart_rdata,
  output logic                        cart_rd,
  output logic                        cart_wr,
  output logic                        cart_cs,
  output logic                        busy
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = $clog2(WAIT_FIRST + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Transaction in flight (address and data live directly in cart_addr/cart_wdata)
  logic [CNT_W-1:0]  cnt;
  logic [PORT_W-1:0] cur_port;
  logic              cur_write;

  // Arbitration and sequential-detection history
  logic [PORT_W-1:0] last_grant;
  logic [PORT_W-1:0] last_port;
  logic              last_write;
  logic [ADDR_W-1:0] last_addr;
  logic              after_recover;

  // Combinational arbitration results
  logic              grant_any;
  logic [PORT_W-1:0] grant_idx;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              seq;
  logic [CNT_W-1:0]  wait_load;

  // Next values of the registered outputs
  logic                 write_nxt;
  logic                 cs_nxt;
  logic                 rd_nxt;
  logic                 wr_nxt;
  logic                 oe_nxt;
  logic                 busy_nxt;
  logic [NUM_PORTS-1:0] rsp_nxt;

  // Search starts one past the last grant so every requestor gets a turn.
  function automatic logic [PORT_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] v,
                                                input logic [PORT_W-1:0]    last);
    logic [PORT_W-1:0] pick;
    logic              found;
    int                idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (!found && v[PORT_W'(idx)]) begin
        found = 1'b1;
        pick  = PORT_W'(idx);
      end
    end
    return pick;
  endfunction

  // Round-robin pick and selection of the winning port's request fields
  always_comb begin
    grant_any    = |req_valid;
    grant_idx    = rr_pick(req_valid, last_grant);
    grant_onehot = grant_any ? (NUM_PORTS'(1) << grant_idx) : '0;
    sel_addr     = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_wdata    = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    sel_write    = req_write[grant_idx];
  end

  // Sequential access detection and wait-count selection; an all-ones last
  // address means the +1 would wrap, which is treated as non-sequential
  always_comb begin
    seq = after_recover
          && (grant_idx == last_port)
          && (sel_write == last_write)
          && (last_addr != '1)
          && (sel_addr == last_addr + ADDR_W'(1));
    wait_load = seq ? CNT_W'(WAIT_SEQ) : CNT_W'(WAIT_FIRST);
  end

  // Accept pulse only while idle and out of reset
  always_comb begin
    req_ready = (state == IDLE && !reset) ? grant_onehot : '0;
  end

  // State register
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ACCESS;
      ACCESS:  if (cnt == CNT_W'(1)) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode for the state being entered, so the registered strobes line
  // up exactly with the state they belong to
  always_comb begin
    write_nxt = (state == IDLE) ? sel_write : cur_write;
    cs_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    oe_nxt    = 1'b0;
    rsp_nxt   = '0;
    busy_nxt  = (state_nxt != IDLE);
    case (state_nxt)
      ACCESS: begin
        cs_nxt = 1'b1;
        rd_nxt = !write_nxt;
        wr_nxt = write_nxt;
        oe_nxt = write_nxt;
      end
      RECOVER: begin
        cs_nxt  = 1'b1;
        rsp_nxt = NUM_PORTS'(1) << cur_port;
      end
      default: ;
    endcase
  end

  // Registered strobes, completion pulse and busy flag
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      cart_cs   <= 1'b0;
      cart_rd   <= 1'b0;
      cart_wr   <= 1'b0;
      cart_oe   <= 1'b0;
      rsp_valid <= '0;
      busy      <= 1'b0;
    end else begin
      cart_cs   <= cs_nxt;
      cart_rd   <= rd_nxt;
      cart_wr   <= wr_nxt;
      cart_oe   <= oe_nxt;
      rsp_valid <= rsp_nxt;
      busy      <= busy_nxt;
    end
  end

  // Transaction datapath: latch on grant, count down in ACCESS, capture read data
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      cart_addr  <= '0;
      cart_wdata <= '0;
      rsp_rdata  <= '0;
      cnt        <= '0;
      cur_port   <= '0;
      cur_write  <= 1'b0;
      last_grant <= PORT_W'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cart_addr  <= sel_addr;
            cart_wdata <= sel_wdata;
            cur_write  <= sel_write;
            cur_port   <= grant_idx;
            last_grant <= grant_idx;
            cnt        <= wait_load;
          end
        end
        ACCESS: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1) && !cur_write) rsp_rdata <= cart_rdata;
        end
        default: ;
      endcase
    end
  end

  // Sequential history, updated when a transaction completes
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      last_addr     <= '0;
      last_port     <= '0;
      last_write    <= 1'b0;
      after_recover <= 1'b0;
    end else begin
      after_recover <= (state == RECOVER);
      if (state == RECOVER) begin
        last_addr  <= cart_addr;
        last_port  <= cur_port;
        last_write <= cur_write;
      end
    end
  end

endmodule

// File: doc/gba_cart_bus_arbiter.md
# gba_cart_bus_arbiter

Parametrised N-port arbiter and cycle-accurate bus sequencer between the GBA core's internal requestors (CPU, DMA, video/prefetch) and the cartridge ROM/SRAM bus. Grants one request at a time by round-robin and drives cart address, strobes and write data for a programmable number of wait cycles. Detects sequential accesses so they use the shorter GBA sequential wait count. Returns read data with a per-port completion pulse. Instantiated in the core top level in place of direct cartridge wiring; the top level owns the tri-state on the cart data pins.

## Interface
- NUM_PORTS, 3, number of requestor ports (≥2)
- ADDR_W, 24, cart halfword address width
- DATA_W, 16, cart data width
- WAIT_FIRST, 4, ACCESS cycles for a non-sequential access (≥1)
- WAIT_SEQ, 2, ACCESS cycles for a sequential access (≥1, ≤WAIT_FIRST)

- clk_74a  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request
- req_write  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*DATA_W  port i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_PORTS  one-cycle accept pulse, one-hot
- rsp_valid  out  NUM_PORTS  one-cycle completion pulse, one-hot
- rsp_rdata  out  DATA_W  read data, valid while rsp_valid is high for a read
- cart_addr  out  ADDR_W  cart address
- cart_wdata  out  DATA_W  cart write data
- cart_oe  out  1  top level drives cart_wdata onto the pins when high
- cart_rdata  in  DATA_W  cart pin data
- cart_rd, cart_wr, cart_cs  out  1 each  active-high cart strobes
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - If any req_valid is high, pick port g by round-robin and pulse req_ready[g] for this cycle.
  - Latch addr, wdata and write for port g, and load the wait counter with W = seq ? WAIT_SEQ : WAIT_FIRST.
  - Next state is ACCESS.
- Round-robin: the search starts at last_grant+1 mod NUM_PORTS. last_grant resets to NUM_PORTS-1, so port 0 wins first.
- Sequential (seq = 1) requires all of the following:
  - The grant occurs in the IDLE cycle immediately after RECOVER.
  - g equals the previous port.
  - req_write equals the previous direction.
  - last_addr is not all-ones and req_addr == last_addr+1 (ADDR_W-bit compare). Wrap to 0 counts as non-sequential.
- ACCESS (exactly W cycles):
  - cart_cs = 1 and cart_addr = latched address.
  - cart_rd = !write, cart_wr = write; cart_oe = write; cart_wdata = latched data.
  - The counter decrements each cycle. On the last cycle (counter == 1), register cart_rdata for reads and go to RECOVER.
- RECOVER (1 cycle):
  - cart_rd, cart_wr and cart_oe are 0; cart_cs stays 1.
  - rsp_valid[g] = 1 and rsp_rdata = registered data. For writes, rsp_rdata holds its previous value.
  - Update last_addr, last port and last direction. Next state is IDLE.
- In IDLE, cart_cs, cart_rd, cart_wr and cart_oe are 0. cart_addr and cart_wdata hold their last values.
- Requestor rules:
  - addr, wdata and write must be stable while req_valid is high and req_ready is low.
  - req_valid may drop before req_ready; the request is then withdrawn with no side effects.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep waiting; they are not dropped.
- Reset (asynchronous, any state):
  - State goes to IDLE and every output goes to 0, including cart_addr, cart_wdata and rsp_rdata.
  - last_grant goes to NUM_PORTS-1 and seq history is cleared.
  - An in-flight transaction is aborted with no rsp_valid.

## Timing
- Accept at cycle T. ACCESS occupies T+1..T+W. rsp_valid is at T+W+1. The earliest next accept is T+W+2.
- Non-seq read at defaults: accept T, rsp T+5, period 6 cycles. Sequential: rsp T+3, period 4 cycles.
- All outputs are registered, except req_ready, which is combinational from req_valid and the state.
- cart_rdata must be stable at the clock edge ending the last ACCESS cycle.
- Counter width is clog2(WAIT_FIRST+1).

## Test plan
- Reset: hold reset high mid-ACCESS of a port-1 read -> all outputs 0 next sample, no rsp_valid, and after release the first grant goes to port 0 when ports 0 and 1 both request.
- Single non-seq read: port 0 reads 0x000100 with cart_rdata = 0xBEEF -> cart_rd high exactly 4 cycles, rsp_valid[0] at T+5, rsp_rdata = 0xBEEF.
- Back-to-back sequential: port 0 reads 0x000100 then immediately 0x000101 -> second ACCESS lasts 2 cycles. A third read at 0x000103 lasts 4 cycles (non-seq).
- Round-robin fairness: all 3 ports hold reads continuously -> grants cycle 0,1,2,0,1,2, and every access is non-seq.
- Write: port 2 writes 0x1234 to 0x0E0000 -> cart_wr and cart_oe high 4 cycles with cart_wdata = 0x1234, rsp_valid[2] at T+5, rsp_rdata unchanged.
- Wrap boundary: read 0xFFFFFF then 0x000000 from the same port back-to-back -> second access uses WAIT_FIRST (4 cycles).
